ram_sp_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 64x8 single-port RAM, which has a synchronous write and a registered read address. It accepts up to one read or write per cycle from either of two requesters and drives the RAM port from registers. It returns read data to the requester that issued the read, with a fixed latency. It sits between two client blocks (e.g. a DMA engine and a CPU-side bus) and one RAM instance.

---
 rtl/ram_sp_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_sp_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_arbiter.sv
// Two-requester arbiter/sequencer for a 64x8 single-port RAM with registered port outputs.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to requester 0.
module ram_sp_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic              gnt0, gnt1, accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              tag_vld_q, tag_vld_d;
  logic              tag_id_q, tag_id_d;
  logic              rsp0_q, rsp0_d;
  logic              rsp1_q, rsp1_d;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q = 1 means requester 1 was granted most recently, so requester 0 wins the next tie.
  logic last_q, last_d;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
        gnt0 = last_q;
        gnt1 = ~last_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign sel_we     = gnt1 ? req1_we    : req0_we;
  assign sel_addr   = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata  = gnt1 ? req1_wdata : req0_wdata;

  always_comb begin
    ram_we_d  = accept & sel_we;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    rd_addr_d = rd_addr_q;
    if (accept && sel_we) begin
      wr_addr_d = sel_addr;
      wdata_d   = sel_wdata;
    end
    if (accept && !sel_we) begin
      rd_addr_d = sel_addr;
    end
    // Tag stage 1 follows the address into the RAM; stage 2 is the response strobe itself.
    tag_vld_d = accept & ~sel_we;
    tag_id_d  = gnt1;
    rsp0_d    = tag_vld_q & ~tag_id_q;
    rsp1_d    = tag_vld_q & tag_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wdata_q   <= '0;
      tag_vld_q <= 1'b0;
      tag_id_q  <= 1'b0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
    end else begin
      ram_we_q  <= ram_we_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wdata_q   <= wdata_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = accept ? gnt1 : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign ram_we         = ram_we_q;
  assign ram_write_addr = wr_addr_q;
  assign ram_read_addr  = rd_addr_q;
  assign ram_data_in    = wdata_q;
  assign rsp0_valid     = rsp0_q;
  assign rsp1_valid     = rsp1_q;
  assign rsp_data       = ram_data_out;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Self-checking bench for ram_sp_arbiter: behavioural RAM, shadow-memory reference model, directed and random tests.
module tb_ram_sp_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [5:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_wdata = '0, req1_wdata = '0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_we;
  logic [7:0] rsp_data, ram_data_in, ram_data_out;
  logic [5:0] ram_write_addr, ram_read_addr;

  always #5 clk = ~clk;

  ram_sp_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Behavioural RAM: synchronous write, registered read address.
  logic [7:0] mem [64];
  logic [5:0] ram_rd_reg;
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data_in;
    ram_rd_reg <= ram_read_addr;
  end
  assign ram_data_out = mem[ram_rd_reg];

  // Reference model state
  typedef struct {int due; bit id; logic [7:0] data;} rsp_t;
  typedef struct {logic rdy0; logic rdy1; logic v0; logic v1; logic [7:0] data;} obs_t;
  rsp_t       pend[$];
  logic [7:0] shadow [64];
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;
`ifdef ARB_ROUND_ROBIN_EN
  bit         prefer1 = 1'b0;
`endif

  // One clock cycle: drive inputs after the falling edge, sample ready, cross the rising edge,
  // sample responses at the next falling edge. e holds what the model expects.
  task automatic run_cycle(input bit v0, input bit we0, input logic [5:0] a0, input logic [7:0] d0,
                           input bit v1, input bit we1, input logic [5:0] a1, input logic [7:0] d1,
                           output obs_t o, output obs_t e);
    bit g0, g1, we;
    logic [5:0] a;
    logic [7:0] d;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #1;
    o.rdy0 = req0_ready;
    o.rdy1 = req1_ready;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
        g1 = prefer1;
        g0 = !prefer1;
`else
        g0 = 1'b1;
`endif
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    e.rdy0 = g0;
    e.rdy1 = g1;
    @(posedge clk);
    edge_n++;
    if (g0 || g1) begin
      we = g1 ? we1 : we0;
      a  = g1 ? a1 : a0;
      d  = g1 ? d1 : d0;
      if (we) shadow[a] = d;
      else pend.push_back('{due: edge_n + 1, id: g1, data: shadow[a]});
`ifdef ARB_ROUND_ROBIN_EN
      prefer1 = g0;
`endif
    end
    @(negedge clk);
    o.v0 = rsp0_valid;
    o.v1 = rsp1_valid;
    o.data = rsp_data;
    e.v0 = 1'b0;
    e.v1 = 1'b0;
    e.data = '0;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      e.v0 = !pend[0].id;
      e.v1 = pend[0].id;
      e.data = pend[0].data;
      void'(pend.pop_front());
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    pend.delete();
`ifdef ARB_ROUND_ROBIN_EN
    prefer1 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    checks++; if (ram_write_addr !== 6'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", ram_write_addr); end
    checks++; if (ram_read_addr !== 6'd0) begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", ram_read_addr); end
    checks++; if (ram_data_in !== 8'd0) begin errors++; $display("FAIL reset_data_in got=%h exp=00", ram_data_in); end
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%b%b exp=00", rsp0_valid, rsp1_valid); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    int pulses = 0, first = -1, last = -1;
    for (int i = 0; i < 130; i++) begin
      if (i < 64) run_cycle(0, 0, '0, '0, 1, 1, 6'(i), 8'(i) ^ 8'hFF, o, e);
      else if (i < 128) run_cycle(0, 0, '0, '0, 1, 0, 6'(i - 64), '0, o, e);
      else run_cycle(0, 0, '0, '0, 0, 0, '0, '0, o, e);
      checks++;
      if (o.rdy0 !== e.rdy0 || o.rdy1 !== e.rdy1 || o.v0 !== e.v0 || o.v1 !== e.v1 || ((e.v0 || e.v1) && o.data !== e.data)) begin
        errors++;
        $display("FAIL b2b cyc %0d: got rdy=%b%b rsp=%b%b data=%h, exp rdy=%b%b rsp=%b%b data=%h",
                 i, o.rdy0, o.rdy1, o.v0, o.v1, o.data, e.rdy0, e.rdy1, e.v0, e.v1, e.data);
      end
      if (o.v1 === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++;
    if (pulses != 64 || last - first != 63) begin
      errors++;
      $display("FAIL b2b_pulses got count=%0d span=%0d exp count=64 span=63", pulses, last - first);
    end
  endtask

  task automatic test_write_read();
    obs_t o, e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: run_cycle(1, 1, 6'd3, 8'hA5, 0, 0, '0, '0, o, e);
        1: run_cycle(1, 0, 6'd3, '0, 0, 0, '0, '0, o, e);
        default: run_cycle(0, 0, '0, '0, 0, 0, '0, '0, o, e);
      endcase
      checks++;
      if (o.rdy0 !== e.rdy0 || o.rdy1 !== e.rdy1 || o.v0 !== e.v0 || o.v1 !== e.v1 || ((e.v0 || e.v1) && o.data !== e.data)) begin
        errors++;
        $display("FAIL wr_rd cyc %0d: got rdy=%b%b rsp=%b%b data=%h, exp rdy=%b%b rsp=%b%b data=%h",
                 i, o.rdy0, o.rdy1, o.v0, o.v1, o.data, e.rdy0, e.rdy1, e.v0, e.v1, e.data);
      end
      checks++;
      if (o.v0 !== (i == 2) || o.v1 !== 1'b0 || (i == 2 && o.data !== 8'hA5)) begin
        errors++;
        $display("FAIL wr_rd_pulse cyc %0d: got rsp=%b%b data=%h, exp rsp0=%b data=a5", i, o.v0, o.v1, o.data, (i == 2));
      end
    end
  endtask

  task automatic test_tie();
    obs_t o, e;
    logic lit0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) run_cycle(1, 0, 6'($urandom_range(0, 63)), '0, 1, 0, 6'($urandom_range(0, 63)), '0, o, e);
      else run_cycle(0, 0, '0, '0, 0, 0, '0, '0, o, e);
      checks++;
      if (o.rdy0 !== e.rdy0 || o.rdy1 !== e.rdy1 || o.v0 !== e.v0 || o.v1 !== e.v1 || ((e.v0 || e.v1) && o.data !== e.data)) begin
        errors++;
        $display("FAIL tie cyc %0d: got rdy=%b%b rsp=%b%b data=%h, exp rdy=%b%b rsp=%b%b data=%h",
                 i, o.rdy0, o.rdy1, o.v0, o.v1, o.data, e.rdy0, e.rdy1, e.v0, e.v1, e.data);
      end
      if (i < 4) begin
`ifdef ARB_ROUND_ROBIN_EN
        lit0 = (i % 2 == 0);
`else
        lit0 = 1'b1;
`endif
        checks++;
        if (o.rdy0 !== lit0 || o.rdy1 !== !lit0) begin
          errors++;
          $display("FAIL tie_grant cyc %0d: got rdy=%b%b exp rdy=%b%b", i, o.rdy0, o.rdy1, lit0, !lit0);
        end
      end
    end
  endtask

  task automatic test_interleaved();
    obs_t o, e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: run_cycle(1, 1, 6'd5, 8'h11, 0, 0, '0, '0, o, e);
        1: run_cycle(0, 0, '0, '0, 1, 1, 6'd6, 8'h22, o, e);
        2: run_cycle(1, 0, 6'd5, '0, 0, 0, '0, '0, o, e);
        3: run_cycle(0, 0, '0, '0, 1, 0, 6'd6, '0, o, e);
        default: run_cycle(0, 0, '0, '0, 0, 0, '0, '0, o, e);
      endcase
      checks++;
      if (o.rdy0 !== e.rdy0 || o.rdy1 !== e.rdy1 || o.v0 !== e.v0 || o.v1 !== e.v1 || ((e.v0 || e.v1) && o.data !== e.data)) begin
        errors++;
        $display("FAIL interleave cyc %0d: got rdy=%b%b rsp=%b%b data=%h, exp rdy=%b%b rsp=%b%b data=%h",
                 i, o.rdy0, o.rdy1, o.v0, o.v1, o.data, e.rdy0, e.rdy1, e.v0, e.v1, e.data);
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (o.v0 !== (i == 3) || o.v1 !== (i == 4) || o.data !== ((i == 3) ? 8'h11 : 8'h22)) begin
          errors++;
          $display("FAIL interleave_route cyc %0d: got rsp=%b%b data=%h", i, o.v0, o.v1, o.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    run_cycle(1, 1, 6'd9, 8'h5A, 0, 0, '0, '0, o, e);
    run_cycle(1, 0, 6'd9, '0, 0, 0, '0, '0, o, e);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_read_addr !== 6'd0 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async got we=%b rd_addr=%0d rsp0=%b rdy0=%b exp 0 0 0 0", ram_we, ram_read_addr, rsp0_valid, req0_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_drop cyc %0d got rsp=%b%b exp 00", i, rsp0_valid, rsp1_valid);
      end
    end
    req0_valid = 1'b0;
    pend.delete();
`ifdef ARB_ROUND_ROBIN_EN
    prefer1 = 1'b0;
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) run_cycle(1, 0, 6'd1, '0, 1, 0, 6'd2, '0, o, e);
      else run_cycle(0, 0, '0, '0, 0, 0, '0, '0, o, e);
      checks++;
      if (o.rdy0 !== e.rdy0 || o.rdy1 !== e.rdy1 || o.v0 !== e.v0 || o.v1 !== e.v1 || ((e.v0 || e.v1) && o.data !== e.data)) begin
        errors++;
        $display("FAIL rst_mid_after cyc %0d: got rdy=%b%b rsp=%b%b data=%h, exp rdy=%b%b rsp=%b%b data=%h",
                 i, o.rdy0, o.rdy1, o.v0, o.v1, o.data, e.rdy0, e.rdy1, e.v0, e.v1, e.data);
      end
      if (i == 0) begin
        checks++;
        if (o.rdy0 !== 1'b1 || o.rdy1 !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_first_tie got rdy=%b%b exp rdy=10", o.rdy0, o.rdy1);
        end
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    for (int i = 0; i < 402; i++) begin
      if (i < 400)
        run_cycle(($urandom_range(0, 9) < 6), 1'($urandom), 6'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 9) < 6), 1'($urandom), 6'($urandom_range(0, 7)), 8'($urandom), o, e);
      else
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0, o, e);
      checks++;
      if (o.rdy0 !== e.rdy0 || o.rdy1 !== e.rdy1 || o.v0 !== e.v0 || o.v1 !== e.v1 || ((e.v0 || e.v1) && o.data !== e.data)) begin
        errors++;
        $display("FAIL random cyc %0d: got rdy=%b%b rsp=%b%b data=%h, exp rdy=%b%b rsp=%b%b data=%h",
                 i, o.rdy0, o.rdy1, o.v0, o.v1, o.data, e.rdy0, e.rdy1, e.v0, e.v1, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_write_read();
    test_tie();
    test_interleaved();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
